toggle_arbiter: RTL and testbench

TOGGLE_ARBITER -- requirements
Module: toggle_arbiter

---
 rtl/toggle_arb_pkg.sv | 14 +
 rtl/t_ff.sv | 21 ++
 rtl/toggle_arbiter.sv | 131 +++++++++++++
 tb/tb_toggle_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_arb_pkg.sv
// Shared definitions for the toggle arbiter: default sizing and FSM state encoding.
package toggle_arb_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_TOGGLE = 2'd2,
        S_ACK    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/t_ff.sv
// Shared T flip-flop; inverts Q on every rising edge where T is high.
module t_ff (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic Q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else if (T) begin
            q_q <= ~q_q;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/toggle_arbiter.sv
// Round-robin arbiter granting one requester at a time a single toggle of a shared T flip-flop.
//   state    | meaning
//   S_IDLE   | waiting; picks a round-robin winner when en=1 and any req is high
//   S_GRANT  | gnt held; winner may still withdraw before anything happens
//   S_TOGGLE | t_out pulsed into the shared flip-flop, gnt held
//   S_ACK    | one-cycle ack to the winner; winner becomes lowest priority
module toggle_arbiter
    import toggle_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             t_out,
    output logic             q,
    output logic             busy,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] last_winner_q;
    logic [IDX_W-1:0] winner_q;
    logic [IDX_W-1:0] winner_d;
    logic             pick_valid;
    logic [N_REQ-1:0] winner_oh;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             t_out_q;
    logic [CNT_W-1:0] cnt_q;

    // Search starts one past the previous winner so every requester is reached within N_REQ picks.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        winner_d   = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand     = (int'(last_winner_q) + i) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                winner_d   = cand_idx;
            end
        end
    end

    always_comb begin
        winner_oh           = '0;
        winner_oh[winner_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            ack_q         <= '0;
            t_out_q       <= 1'b0;
            cnt_q         <= '0;
            winner_q      <= LAST_IDX;
            last_winner_q <= LAST_IDX;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= '0;
                    if (en && pick_valid) begin
                        winner_q <= winner_d;
                        gnt_q    <= winner_oh;
                        state_q  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (req[winner_q]) begin
                        t_out_q <= 1'b1;
                        state_q <= S_TOGGLE;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_TOGGLE: begin
                    t_out_q <= 1'b0;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    ack_q   <= gnt_q;
                    gnt_q   <= '0;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    ack_q         <= '0;
                    last_winner_q <= winner_q;
                    state_q       <= S_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    t_out_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    t_ff u_t_ff (
        .clk (clk),
        .rst (rst),
        .T   (t_out_q),
        .Q   (q)
    );

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign t_out      = t_out_q;
    assign busy       = (state_q != S_IDLE);
    assign toggle_cnt = cnt_q;

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt_q) && $onehot0(ack_q) && !((|gnt_q) && (|ack_q)));

    a_tout_toggle: assert property (@(posedge clk) disable iff (rst)
        t_out_q |-> (state_q == S_TOGGLE));

endmodule

// File: tb/tb_toggle_arbiter.sv
// Bench for toggle_arbiter: cycle table for reset/single/withdrawal, scoreboard of acks for longer sequences.
module tb_toggle_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          t_out;
    logic          q;
    logic          busy;
    logic [CW-1:0] toggle_cnt;

    always #5 clk = ~clk;

    toggle_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .gnt        (gnt),
        .ack        (ack),
        .t_out      (t_out),
        .q          (q),
        .busy       (busy),
        .toggle_cnt (toggle_cnt)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       t;
        logic       q;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        int         w;
        logic       q;
        logic [7:0] cnt;
    } sb_t;

    localparam int NV = 17;
    vec_t tv[NV];
    sb_t  sb_q[$];

    int         n_chk = 0;
    int         n_err = 0;
    bit         sb_on = 1'b0;
    logic       exp_q;
    logic [7:0] exp_cnt;

    logic [3:0] s_gnt, s_ack;
    logic       s_t, s_q, s_busy;
    logic [7:0] s_cnt;

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] rq,
                                input logic [3:0] g, input logic [3:0] a, input logic t,
                                input logic qq, input logic b, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.en = e; v.req = rq; v.gnt = g; v.ack = a;
        v.t = t; v.q = qq; v.busy = b; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ack(input int w);
        sb_t e;
        exp_q   = ~exp_q;
        exp_cnt = exp_cnt + 8'd1;
        e.w     = w;
        e.q     = exp_q;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs, sample at the falling edge, run the ack monitor, return just after the next rising edge.
    task automatic tick(input logic r, input logic e, input logic [3:0] rq);
        sb_t        ent;
        logic [3:0] oh;
        rst = r; en = e; req = rq;
        @(negedge clk);
        s_gnt = gnt; s_ack = ack; s_t = t_out; s_q = q; s_busy = busy; s_cnt = toggle_cnt;
        chk("inv_onehot", 32'($onehot0(s_gnt) && $onehot0(s_ack) && !((|s_gnt) && (|s_ack))), 32'd1);
        chk("inv_tout_gnt", 32'(!s_t || (|s_gnt)), 32'd1);
        if (sb_on && (|s_ack)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", 32'(s_ack), 32'd0);
            end else begin
                ent = sb_q.pop_front();
                oh  = 4'b0001 << ent.w;
                chk("sb_ack", 32'(s_ack), 32'(oh));
                chk("sb_q", 32'(s_q), 32'(ent.q));
                chk("sb_cnt", 32'(s_cnt), 32'(ent.cnt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        sb_q.delete();
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b1, 1'b0, 4'h0);
        exp_q   = 1'b0;
        exp_cnt = 8'd0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'h0;
        exp_q = 1'b0; exp_cnt = 8'd0;

        //          rst   en    req    gnt    ack    t_out q     busy  cnt
        tv[0]  = mk(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        tv[1]  = mk(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        tv[2]  = mk(1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        tv[3]  = mk(1'b0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 8'd0);
        tv[4]  = mk(1'b0, 1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 8'd0);
        tv[5]  = mk(1'b0, 1'b1, 4'h4, 4'h0, 4'h4, 1'b0, 1'b1, 1'b1, 8'd1);
        tv[6]  = mk(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1);
        tv[7]  = mk(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1);
        tv[8]  = mk(1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1);
        tv[9]  = mk(1'b0, 1'b1, 4'h0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1, 8'd1);
        tv[10] = mk(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1);
        tv[11] = mk(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1);
        tv[12] = mk(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd1);
        tv[13] = mk(1'b0, 1'b1, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 1'b1, 8'd1);
        tv[14] = mk(1'b0, 1'b1, 4'hF, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1, 8'd1);
        tv[15] = mk(1'b0, 1'b1, 4'h7, 4'h0, 4'h8, 1'b0, 1'b0, 1'b1, 8'd2);
        tv[16] = mk(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd2);

        @(posedge clk);
        #1;

        // Reset hold, single request on 2, withdrawal by 1, then priority continues after 2 (not 1).
        for (int k = 0; k < NV; k++) begin
            tick(tv[k].rst, tv[k].en, tv[k].req);
            chk($sformatf("vec%0d.gnt", k),  32'(s_gnt),  32'(tv[k].gnt));
            chk($sformatf("vec%0d.ack", k),  32'(s_ack),  32'(tv[k].ack));
            chk($sformatf("vec%0d.tout", k), 32'(s_t),    32'(tv[k].t));
            chk($sformatf("vec%0d.q", k),    32'(s_q),    32'(tv[k].q));
            chk($sformatf("vec%0d.busy", k), 32'(s_busy), 32'(tv[k].busy));
            chk($sformatf("vec%0d.cnt", k),  32'(s_cnt),  32'(tv[k].cnt));
        end

        // Round-robin with all requesters held.
        do_reset();
        sb_on = 1'b1;
        expect_ack(0); expect_ack(1); expect_ack(2); expect_ack(3); expect_ack(0);
        repeat (20) tick(1'b0, 1'b1, 4'hF);
        repeat (2) tick(1'b0, 1'b1, 4'h0);
        chk("rr_drained", 32'(sb_q.size()), 32'd0);
        chk("rr_cnt", 32'(s_cnt), 32'd5);

        // Enable blocks new arbitration only; an in-flight transaction completes.
        do_reset();
        sb_on = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 4'h1);
            chk("en0_gnt", 32'(s_gnt), 32'd0);
            chk("en0_busy", 32'(s_busy), 32'd0);
        end
        expect_ack(0); expect_ack(0);
        tick(1'b0, 1'b1, 4'h1);
        repeat (3) tick(1'b0, 1'b0, 4'h1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 4'h1);
            chk("en_hold_busy", 32'(s_busy), 32'd0);
        end
        chk("en_first_done", 32'(sb_q.size()), 32'd1);
        repeat (4) tick(1'b0, 1'b1, 4'h1);
        repeat (2) tick(1'b0, 1'b1, 4'h0);
        chk("en_drained", 32'(sb_q.size()), 32'd0);

        // Counter wrap: 255 toggles, then one more wraps to zero.
        do_reset();
        repeat (1020) tick(1'b0, 1'b1, 4'h1);
        chk("wrap_pre_cnt", 32'(toggle_cnt), 32'd255);
        chk("wrap_pre_q", 32'(q), 32'd1);
        exp_q   = 1'b1;
        exp_cnt = 8'd255;
        sb_on   = 1'b1;
        expect_ack(0);
        repeat (4) tick(1'b0, 1'b1, 4'h1);
        repeat (2) tick(1'b0, 1'b1, 4'h0);
        chk("wrap_drained", 32'(sb_q.size()), 32'd0);
        chk("wrap_cnt", 32'(s_cnt), 32'd0);

        // Reset landing in TOGGLE aborts with no toggle and no ack.
        do_reset();
        sb_on = 1'b1;
        tick(1'b0, 1'b1, 4'h2);
        tick(1'b0, 1'b1, 4'h2);
        chk("abort_gnt", 32'(s_gnt), 32'd2);
        tick(1'b1, 1'b1, 4'h2);
        chk("abort_tout", 32'(s_t), 32'd1);
        tick(1'b0, 1'b1, 4'h0);
        chk("abort_q", 32'(s_q), 32'd0);
        chk("abort_cnt", 32'(s_cnt), 32'd0);
        chk("abort_ack", 32'(s_ack), 32'd0);
        chk("abort_gnt0", 32'(s_gnt), 32'd0);
        chk("abort_busy", 32'(s_busy), 32'd0);
        repeat (3) tick(1'b0, 1'b1, 4'h0);
        chk("abort_q_after", 32'(s_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
